// File: rtl/count_seq_pkg.sv
// Shared definitions for the counter-sequence checker: FSM states, the
// default counter width and the modulo +1 helper.
package count_seq_pkg;

   localparam int CNT_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SYNC  = 2'd1,
      TRACK = 2'd2,
      ERROR = 2'd3
   } cs_state_e;

   // +1 modulo 2^width; callers cast the result down to their own width.
   function automatic logic [31:0] cnt_next(input logic [31:0] val, input int width);
      logic [31:0] mask;
      mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (val + 32'd1) & mask;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, used for the wrap count.
// Only built when COUNT_SEQ_WRAP_CNT_EN is defined.
`ifdef COUNT_SEQ_WRAP_CNT_EN
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   localparam logic [W-1:0] MAX_C = {W{1'b1}};

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {W{1'b0}};
      end else if (inc_i && (cnt_q != MAX_C)) begin
         cnt_d = cnt_q + W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk_i) begin
      cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/count_seq_checker.sv
// Checks that a counter stream advances by exactly +1 per clock, flags wraps
// once locked and latches the first violation. Wrap counter under COUNT_SEQ_WRAP_CNT_EN.
module count_seq_checker
   import count_seq_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int WRAP_W   = 8,
   parameter int SYNC_LEN = 2
) (
   input  logic              clk,
   input  logic              rst_h,
   input  logic [CNT_W-1:0]  cnt_in,
   input  logic              clr_err,
   output logic              locked,
   output logic              wrap_pulse,
   output logic [WRAP_W-1:0] wrap_cnt,
   output logic              err,
   output logic [CNT_W-1:0]  err_exp,
   output logic [CNT_W-1:0]  err_got
);

   localparam logic [CNT_W-1:0] CNT_MAX_C  = {CNT_W{1'b1}};
   localparam logic [3:0]       SYNC_LEN_C = 4'(SYNC_LEN);

   cs_state_e        state_q, state_d;
   logic [CNT_W-1:0] prev_q, prev_d;
   logic [3:0]       good_run_q, good_run_d;
   logic             locked_q, locked_d;
   logic             wrap_pulse_q, wrap_pulse_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] err_exp_q, err_exp_d;
   logic [CNT_W-1:0] err_got_q, err_got_d;

   logic [CNT_W-1:0] prev_plus_s;
   logic [3:0]       good_run_inc_s;
   logic             good_s;

   assign prev_plus_s    = CNT_W'(cnt_next(32'(prev_q), CNT_W));
   assign good_s         = (cnt_in == prev_plus_s);
   assign good_run_inc_s = good_run_q + 4'd1;

   always_comb begin
      state_d      = state_q;
      prev_d       = cnt_in;
      good_run_d   = good_run_q;
      wrap_pulse_d = 1'b0;
      err_d        = err_q;
      err_exp_d    = err_exp_q;
      err_got_d    = err_got_q;
      case (state_q)
         IDLE: begin
            good_run_d = 4'd0;
            state_d    = SYNC;
         end
         SYNC: begin
            if (good_s) begin
               good_run_d = good_run_inc_s;
               if (good_run_inc_s == SYNC_LEN_C) begin
                  state_d = TRACK;
               end else begin
                  state_d = SYNC;
               end
            end else begin
               good_run_d = 4'd0;
            end
         end
         TRACK: begin
            if (good_s) begin
               wrap_pulse_d = (prev_q == CNT_MAX_C);
            end else begin
               state_d   = ERROR;
               err_d     = 1'b1;
               err_exp_d = prev_plus_s;
               err_got_d = cnt_in;
            end
         end
         ERROR: begin
            // The stream is ignored here; only clr_err can leave.
            prev_d = prev_q;
            if (clr_err) begin
               state_d   = IDLE;
               err_d     = 1'b0;
               err_exp_d = {CNT_W{1'b0}};
               err_got_d = {CNT_W{1'b0}};
            end else begin
               state_d = ERROR;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      locked_d = (state_d == TRACK);
   end

   always_ff @(posedge clk) begin
      if (rst_h) begin
         state_q      <= IDLE;
         prev_q       <= {CNT_W{1'b0}};
         good_run_q   <= 4'd0;
         locked_q     <= 1'b0;
         wrap_pulse_q <= 1'b0;
         err_q        <= 1'b0;
         err_exp_q    <= {CNT_W{1'b0}};
         err_got_q    <= {CNT_W{1'b0}};
      end else begin
         state_q      <= state_d;
         prev_q       <= prev_d;
         good_run_q   <= good_run_d;
         locked_q     <= locked_d;
         wrap_pulse_q <= wrap_pulse_d;
         err_q        <= err_d;
         err_exp_q    <= err_exp_d;
         err_got_q    <= err_got_d;
      end
   end

`ifdef COUNT_SEQ_WRAP_CNT_EN
   // Steps on the same edge that raises wrap_pulse; reset acts as its clear.
   sat_counter #(
      .W (WRAP_W)
   ) u_wrap_cnt (
      .clk_i (clk),
      .clr_i (rst_h),
      .inc_i (wrap_pulse_d),
      .cnt_o (wrap_cnt)
   );
`else
   assign wrap_cnt = {WRAP_W{1'b0}};
`endif

   assign locked     = locked_q;
   assign wrap_pulse = wrap_pulse_q;
   assign err        = err_q;
   assign err_exp    = err_exp_q;
   assign err_got    = err_got_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Randomized bench for count_seq_checker against a behavioural model of the
// sequence rules; wrap_cnt expectation follows COUNT_SEQ_WRAP_CNT_EN.
module tb_count_seq_checker;

   localparam int CNT_W    = 4;
   localparam int WRAP_W   = 8;
   localparam int SYNC_LEN = 2;
   localparam int MOD      = 1 << CNT_W;
   localparam int WRAP_MAX = (1 << WRAP_W) - 1;

   logic              clk = 1'b0;
   logic              rst_h;
   logic [CNT_W-1:0]  cnt_in;
   logic              clr_err;
   logic              locked;
   logic              wrap_pulse;
   logic [WRAP_W-1:0] wrap_cnt;
   logic              err;
   logic [CNT_W-1:0]  err_exp;
   logic [CNT_W-1:0]  err_got;

   count_seq_checker #(
      .CNT_W    (CNT_W),
      .WRAP_W   (WRAP_W),
      .SYNC_LEN (SYNC_LEN)
   ) dut (
      .clk        (clk),
      .rst_h      (rst_h),
      .cnt_in     (cnt_in),
      .clr_err    (clr_err),
      .locked     (locked),
      .wrap_pulse (wrap_pulse),
      .wrap_cnt   (wrap_cnt),
      .err        (err),
      .err_exp    (err_exp),
      .err_got    (err_got)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: where the stream stands, not how the FSM encodes it.
   int m_prev, m_run, m_wraps, m_exp, m_got;
   bit m_fresh, m_locked, m_err, m_pulse;
   int cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   task automatic model_update(input bit rst, input int s, input bit clr);
      bit good;
      m_pulse = 1'b0;
      if (rst) begin
         m_prev = 0; m_run = 0; m_wraps = 0; m_exp = 0; m_got = 0;
         m_fresh = 1'b1; m_locked = 1'b0; m_err = 1'b0;
      end else if (m_err) begin
         if (clr) begin
            m_err = 1'b0; m_exp = 0; m_got = 0; m_fresh = 1'b1;
         end
      end else if (m_fresh) begin
         m_prev = s; m_run = 0; m_fresh = 1'b0;
      end else begin
         good = (((m_prev + 1) % MOD) == s);
         if (!m_locked) begin
            if (good) begin
               m_run++;
               if (m_run == SYNC_LEN) m_locked = 1'b1;
            end else begin
               m_run = 0;
            end
         end else if (good) begin
            if (m_prev == MOD - 1) begin
               m_pulse = 1'b1;
               if (m_wraps < WRAP_MAX) m_wraps++;
            end
         end else begin
            m_err = 1'b1; m_locked = 1'b0;
            m_exp = (m_prev + 1) % MOD; m_got = s;
         end
         m_prev = s;
      end
   endtask

   task automatic step(input bit rst, input int s, input bit clr);
      int exp_wraps;
      rst_h   = rst;
      cnt_in  = CNT_W'(s);
      clr_err = clr;
      @(posedge clk);
      model_update(rst, s % MOD, clr);
      #1;
`ifdef COUNT_SEQ_WRAP_CNT_EN
      exp_wraps = m_wraps;
`else
      exp_wraps = 0;
`endif
      check("locked",     32'(locked),     32'(m_locked));
      check("wrap_pulse", 32'(wrap_pulse), 32'(m_pulse));
      check("wrap_cnt",   32'(wrap_cnt),   32'(exp_wraps));
      check("err",        32'(err),        32'(m_err));
      check("err_exp",    32'(err_exp),    32'(m_exp));
      check("err_got",    32'(err_got),    32'(m_got));
   endtask

   task automatic run_legal(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b0, cnt, 1'b0);
         cnt = (cnt + 1) % MOD;
      end
   endtask

   initial begin
      int glitch [5] = '{0, 1, 9, 10, 11};
      rst_h = 1'b1; cnt_in = '0; clr_err = 1'b0;
      cnt = 0;

      // Reset release with a free-running counter, several wraps
      for (int i = 0; i < 3; i++) step(1'b1, 0, 1'b0);
      run_legal(40);

      // Skip error: 5 then 7, then garbage held off for 20 cycles
      while (cnt != 6) run_legal(1);
      step(1'b0, 7, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, $urandom_range(0, MOD - 1), 1'b0);

      // Clear (with a bad sample alongside) and relock from a random start
      step(1'b0, $urandom_range(0, MOD - 1), 1'b1);
      cnt = $urandom_range(0, MOD - 1);
      run_legal(30);

      // Glitch in SYNC, then error and reset while in ERROR
      step(1'b1, 0, 1'b0);
      foreach (glitch[i]) step(1'b0, glitch[i], 1'b0);
      cnt = 12;
      run_legal(10);
      step(1'b0, (cnt + 3) % MOD, 1'b0);
      step(1'b0, 4, 1'b0);
      step(1'b1, 0, 1'b0);
      cnt = 0;
      run_legal(8);

      // clr_err while tracking must be ignored
      for (int i = 0; i < 40; i++) begin
         step(1'b0, cnt, 1'($urandom_range(0, 1)));
         cnt = (cnt + 1) % MOD;
      end

      // Long legal run drives the wrap count into saturation
      run_legal(4200);

      // Random mix: jumps, clears and occasional resets
      for (int i = 0; i < 3000; i++) begin
         bit r, c;
         r = ($urandom_range(0, 199) == 0);
         c = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 19) == 0) cnt = $urandom_range(0, MOD - 1);
         if (r) cnt = 0;
         step(r, cnt, c);
         cnt = (cnt + 1) % MOD;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
